// File: rtl/logic_capture_pkg.sv
// Shared types and constants for the logic analyser capture packer.
package logic_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } capture_state_t;

    // Header words carry an all-ones slot count; callers truncate to NV_W bits.
    localparam logic [31:0] HDR_NVALID = '1;

    function automatic int unsigned calc_lanes(input int unsigned sample_width,
                                               input int unsigned out_width);
        return out_width / sample_width;
    endfunction

    function automatic int unsigned calc_nv_w(input int unsigned lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/logic_sample_packer.sv
// Slot register and write pointer: packs accepted samples into output words,
// emitting a full word or, on flush, a terminated partial word one clock later.
module logic_sample_packer
    import logic_capture_pkg::*;
#(
    parameter  int unsigned SAMPLE_WIDTH = 16,
    parameter  int unsigned OUT_WIDTH    = 128,
    localparam int unsigned LANES        = calc_lanes(SAMPLE_WIDTH, OUT_WIDTH),
    localparam int unsigned NV_W         = calc_nv_w(LANES),
    localparam int unsigned PTR_W        = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    accept,
    input  logic                    flush,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    output logic                    word_valid,
    output logic [OUT_WIDTH-1:0]    word_data,
    output logic [NV_W-1:0]         word_nvalid,
    output logic                    word_last
);

    logic [OUT_WIDTH-1:0] slots_q;
    logic [OUT_WIDTH-1:0] slots_next;
    logic [PTR_W-1:0]     ptr_q;
    logic [NV_W-1:0]      fill;
    logic                 emit;

    // A sample accepted alongside a flush is folded into the final word.
    always_comb begin
        slots_next = slots_q;
        fill       = NV_W'(ptr_q);
        if (accept) begin
            slots_next[ptr_q * SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_data;
            fill = NV_W'(ptr_q) + NV_W'(1);
        end
        emit = flush || (accept && (ptr_q == PTR_W'(LANES - 1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q     <= '0;
            ptr_q       <= '0;
            word_valid  <= 1'b0;
            word_data   <= '0;
            word_nvalid <= '0;
            word_last   <= 1'b0;
        end else begin
            word_valid <= emit;
            word_last  <= flush;
            if (emit) begin
                word_data   <= slots_next;
                word_nvalid <= fill;
                slots_q     <= '0;
                ptr_q       <= '0;
            end else begin
                word_data   <= '0;
                word_nvalid <= '0;
                slots_q     <= slots_next;
                if (accept) begin
                    ptr_q <= ptr_q + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/logic_capture_packer.sv
// Per-port capture stage: capture FSM, sample counter and overflow flag around the packer.
// Optional LOGIC_CAPTURE_TIMESTAMP_EN adds a cycle counter and a timestamp header word.
module logic_capture_packer
    import logic_capture_pkg::*;
#(
    parameter  int unsigned SAMPLE_WIDTH = 16,
    parameter  int unsigned OUT_WIDTH    = 128,
    localparam int unsigned LANES        = calc_lanes(SAMPLE_WIDTH, OUT_WIDTH),
    localparam int unsigned NV_W         = calc_nv_w(LANES)
) (
    input  logic                    clk_312p5mhz,
    input  logic                    trig_rst,
    input  logic                    capture_en,
    input  logic                    capture_flush,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [OUT_WIDTH-1:0]    fifo_wr_data,
    output logic [NV_W-1:0]         fifo_wr_nvalid,
    output logic                    fifo_wr_last,
    output logic                    overflow,
    output logic [31:0]             sample_count
);

    capture_state_t state_q, state_d;

    logic                 accept;
    logic                 flush_in;
    logic                 entry;
    logic                 pk_flush;
    logic                 pk_valid;
    logic [OUT_WIDTH-1:0] pk_data;
    logic [NV_W-1:0]      pk_nvalid;
    logic                 pk_last;

    assign accept   = capture_en && (state_q != DONE);
    assign flush_in = capture_flush && (state_q != DONE);
    assign entry    = capture_en && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush_in) begin
                    state_d = DONE;
                end else if (capture_en) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (flush_in) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_312p5mhz) begin
        if (trig_rst) begin
            state_q      <= IDLE;
            overflow     <= 1'b0;
            sample_count <= '0;
        end else begin
            state_q <= state_d;
            if (fifo_wr_en && fifo_full) begin
                overflow <= 1'b1;
            end
            if (accept && (sample_count != '1)) begin
                sample_count <= sample_count + 32'd1;
            end
        end
    end

    logic_sample_packer #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH)
    ) u_packer (
        .clk        (clk_312p5mhz),
        .rst        (trig_rst),
        .accept     (accept),
        .flush      (pk_flush),
        .sample_data(sample_data),
        .word_valid (pk_valid),
        .word_data  (pk_data),
        .word_nvalid(pk_nvalid),
        .word_last  (pk_last)
    );

`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
    logic [63:0] cycle_q;
    logic [63:0] ts_q;
    logic        hdr_q;
    logic        flush_hold_q;

    // A flush on the entry cycle is deferred one clock so the header goes out first.
    always_ff @(posedge clk_312p5mhz) begin
        if (trig_rst) begin
            cycle_q      <= '0;
            ts_q         <= '0;
            hdr_q        <= 1'b0;
            flush_hold_q <= 1'b0;
        end else begin
            cycle_q      <= cycle_q + 64'd1;
            hdr_q        <= entry;
            flush_hold_q <= entry && flush_in;
            if (entry) begin
                ts_q <= cycle_q;
            end
        end
    end

    assign pk_flush       = (flush_in && !entry) || flush_hold_q;
    assign fifo_wr_en     = hdr_q || pk_valid;
    assign fifo_wr_data   = hdr_q ? OUT_WIDTH'(ts_q) : pk_data;
    assign fifo_wr_nvalid = hdr_q ? NV_W'(HDR_NVALID) : pk_nvalid;
    assign fifo_wr_last   = hdr_q ? 1'b0 : pk_last;
`else
    logic unused_entry;

    assign unused_entry   = entry;
    assign pk_flush       = flush_in;
    assign fifo_wr_en     = pk_valid;
    assign fifo_wr_data   = pk_data;
    assign fifo_wr_nvalid = pk_nvalid;
    assign fifo_wr_last   = pk_last;
`endif

endmodule

// File: tb/tb_logic_capture_packer.sv
// Directed, table-driven bench for logic_capture_packer (SAMPLE_WIDTH=16, OUT_WIDTH=128).
module tb_logic_capture_packer;

    logic         clk = 1'b0;
    logic         trig_rst = 1'b1;
    logic         capture_en = 1'b0;
    logic         capture_flush = 1'b0;
    logic         fifo_full = 1'b0;
    logic [15:0]  sample_data = '0;
    logic         fifo_wr_en;
    logic [127:0] fifo_wr_data;
    logic [3:0]   fifo_wr_nvalid;
    logic         fifo_wr_last;
    logic         overflow;
    logic [31:0]  sample_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic_capture_packer #(
        .SAMPLE_WIDTH(16),
        .OUT_WIDTH   (128)
    ) dut (
        .clk_312p5mhz  (clk),
        .trig_rst      (trig_rst),
        .capture_en    (capture_en),
        .capture_flush (capture_flush),
        .sample_data   (sample_data),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_wr_nvalid(fifo_wr_nvalid),
        .fifo_wr_last  (fifo_wr_last),
        .overflow      (overflow),
        .sample_count  (sample_count)
    );

    // One record per clock: inputs for the cycle, expected outputs after its edge.
    typedef struct {
        logic         rst;
        logic         en;
        logic         flush;
        logic         full;
        logic [15:0]  data;
        logic         exp_wr;
        logic [3:0]   exp_nv;
        logic         exp_last;
        logic [127:0] exp_word;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] pack(input logic [15:0] base, input int n);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < n; k++) begin
            w[k*16 +: 16] = base + 16'(k);
        end
        return w;
    endfunction

    function automatic void add(input logic rst, input logic en, input logic flush,
                                input logic full, input logic [15:0] data,
                                input logic exp_wr, input logic [3:0] exp_nv,
                                input logic exp_last, input logic [127:0] exp_word,
                                input logic exp_ovf);
        vec_t v;
        v.rst = rst; v.en = en; v.flush = flush; v.full = full; v.data = data;
        v.exp_wr = exp_wr; v.exp_nv = exp_nv; v.exp_last = exp_last;
        v.exp_word = exp_word; v.exp_ovf = exp_ovf;
        vecs.push_back(v);
    endfunction

    function automatic void add_idle(input logic exp_ovf);
        add(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, '0, exp_ovf);
    endfunction

    function automatic void add_rst();
        add(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, '0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic flush,
                         input logic full, input logic [15:0] data);
        trig_rst      = rst;
        capture_en    = en;
        capture_flush = flush;
        fifo_full     = full;
        sample_data   = data;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].flush, vecs[i].full, vecs[i].data);
            chk($sformatf("%s[%0d].wr_en", tag, i), 128'(fifo_wr_en), 128'(vecs[i].exp_wr));
            chk($sformatf("%s[%0d].overflow", tag, i), 128'(overflow), 128'(vecs[i].exp_ovf));
            if (vecs[i].exp_wr) begin
                chk($sformatf("%s[%0d].nvalid", tag, i), 128'(fifo_wr_nvalid), 128'(vecs[i].exp_nv));
                chk($sformatf("%s[%0d].last", tag, i), 128'(fifo_wr_last), 128'(vecs[i].exp_last));
                chk($sformatf("%s[%0d].data", tag, i), fifo_wr_data, vecs[i].exp_word);
            end
        end
        vecs.delete();
    endtask

    initial begin
`ifndef LOGIC_CAPTURE_TIMESTAMP_EN
        // Continuous capture of 16 samples: two full words, one clock after slots 7 and 15.
        add_rst();
        for (int i = 0; i < 16; i++) begin
            add(1'b0, 1'b1, 1'b0, 1'b0, 16'(i), (i % 8) == 7, 4'd8, 1'b0,
                pack(16'(i - 7), 8), 1'b0);
        end
        add_idle(1'b0);
        run_table("full_words");
        chk("full_words.count", 128'(sample_count), 128'd16);

        // 11 samples then flush: full word, then a 3-slot final word; DONE ignores inputs.
        add_rst();
        for (int i = 0; i < 11; i++) begin
            add(1'b0, 1'b1, 1'b0, 1'b0, 16'h100 + 16'(i), i == 7, 4'd8, 1'b0,
                pack(16'h100, 8), 1'b0);
        end
        add(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 4'd3, 1'b1, pack(16'h108, 3), 1'b0);
        for (int i = 0; i < 6; i++) begin
            add(1'b0, 1'b1, 1'b0, 1'b0, 16'h1F0 + 16'(i), 1'b0, 4'd0, 1'b0, '0, 1'b0);
        end
        add(1'b0, 1'b1, 1'b1, 1'b0, 16'h1FF, 1'b0, 4'd0, 1'b0, '0, 1'b0);
        run_table("partial_flush");
        chk("partial_flush.count", 128'(sample_count), 128'd11);

        // Flush together with the 8th sample: one write, full and last.
        add_rst();
        for (int i = 0; i < 8; i++) begin
            add(1'b0, 1'b1, i == 7, 1'b0, 16'h200 + 16'(i), i == 7, 4'd8, 1'b1,
                pack(16'h200, 8), 1'b0);
        end
        add_idle(1'b0);
        add_idle(1'b0);
        run_table("flush_on_full");
        chk("flush_on_full.count", 128'(sample_count), 128'd8);

        // Flush with an empty slot register: terminator word.
        add_rst();
        for (int i = 0; i < 8; i++) begin
            add(1'b0, 1'b1, 1'b0, 1'b0, 16'h300 + 16'(i), i == 7, 4'd8, 1'b0,
                pack(16'h300, 8), 1'b0);
        end
        add(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 4'd0, 1'b1, '0, 1'b0);
        add_idle(1'b0);
        // Flush in IDLE with no capture also terminates.
        add_rst();
        add(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 4'd0, 1'b1, '0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 16'h3AA, 1'b0, 4'd0, 1'b0, '0, 1'b0);
        run_table("terminator");
        chk("terminator.count", 128'(sample_count), 128'd0);

        // FIFO full while the 2nd word is written: sticky overflow, 3rd word intact.
        add_rst();
        for (int i = 0; i < 24; i++) begin
            add(1'b0, 1'b1, 1'b0, i == 16, 16'h400 + 16'(i), (i % 8) == 7, 4'd8, 1'b0,
                pack(16'h400 + 16'(i - 7), 8), i >= 16);
        end
        add_idle(1'b1);
        add_rst();
        run_table("overflow");

        // Reset in the middle of a word discards it and restarts at slot 0.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h4F0 + 16'(i));
            chk("midrst.pre_wr", 128'(fifo_wr_en), 128'd0);
        end
        chk("midrst.pre_count", 128'(sample_count), 128'd5);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'hDEAD);
        chk("midrst.wr_en", 128'(fifo_wr_en), 128'd0);
        chk("midrst.data", fifo_wr_data, 128'd0);
        chk("midrst.nvalid", 128'(fifo_wr_nvalid), 128'd0);
        chk("midrst.last", 128'(fifo_wr_last), 128'd0);
        chk("midrst.overflow", 128'(overflow), 128'd0);
        chk("midrst.count", 128'(sample_count), 128'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("midrst.after_wr", 128'(fifo_wr_en), 128'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h500 + 16'(i));
            chk("midrst.wr_en", 128'(fifo_wr_en), 128'(i == 7));
        end
        chk("midrst.word", fifo_wr_data, pack(16'h500, 8));
        chk("midrst.word_nv", 128'(fifo_wr_nvalid), 128'd8);
        chk("midrst.word_count", 128'(sample_count), 128'd8);
`else
        // Header after 100 idle clocks carries ts=100, then the data word.
        add_rst();
        for (int i = 0; i < 100; i++) begin
            add_idle(1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                add(1'b0, 1'b1, 1'b0, 1'b0, 16'h600, 1'b1, 4'hF, 1'b0, 128'd100, 1'b0);
            end else begin
                add(1'b0, 1'b1, 1'b0, 1'b0, 16'h600 + 16'(i), i == 7, 4'd8, 1'b0,
                    pack(16'h600, 8), 1'b0);
            end
        end
        add(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 4'd0, 1'b1, '0, 1'b0);
        add_idle(1'b0);
        // Flush on the entry cycle: header first, final one-sample word next.
        add_rst();
        add(1'b0, 1'b1, 1'b1, 1'b0, 16'h700, 1'b1, 4'hF, 1'b0, 128'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 4'd1, 1'b1, pack(16'h700, 1), 1'b0);
        add_idle(1'b0);
        run_table("timestamp");
        chk("timestamp.count", 128'(sample_count), 128'd1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
